// File: rtl/sram_arbiter_if.sv
// Requester-side bus of sram_arbiter: per-port request payload packed flat,
// port p at slice p, plus the shared grant / read-return signals.
interface sram_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 1024
);
  localparam int AW = $clog2(NUM_WORDS);
  localparam int BW = (DATA_WIDTH + 7) / 8;

  logic [NUM_PORTS-1:0]            req_i;
  logic [NUM_PORTS-1:0]            we_i;
  logic [NUM_PORTS*AW-1:0]         addr_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_PORTS*BW-1:0]         be_i;
  logic [NUM_PORTS-1:0]            gnt_o;
  logic [NUM_PORTS-1:0]            rvalid_o;
  logic [DATA_WIDTH-1:0]           rdata_o;
  logic                            init_done_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i,
    input  gnt_o, rvalid_o, rdata_o, init_done_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    output gnt_o, rvalid_o, rdata_o, init_done_o
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin N:1 arbiter onto a single-port SRAM that zero-fills the array
// after reset. Optional sticky-grant lock enabled by macro SRAM_ARB_LOCK_EN.
module sram_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 1024
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
`ifdef SRAM_ARB_LOCK_EN
  input  logic [NUM_PORTS-1:0]              lock_i,
`endif
  sram_arbiter_if.slave                     bus,
  output logic                              sram_req_o,
  output logic                              sram_we_o,
  output logic [$clog2(NUM_WORDS)-1:0]      sram_addr_o,
  output logic [DATA_WIDTH-1:0]             sram_wdata_o,
  output logic [(DATA_WIDTH+7)/8-1:0]       sram_be_o,
  input  logic [DATA_WIDTH-1:0]             sram_rdata_i
);
  localparam int AW = $clog2(NUM_WORDS);
  localparam int BW = (DATA_WIDTH + 7) / 8;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {S_INIT, S_ARB} state_e;

  state_e               r_state, w_state_nxt;
  logic [AW-1:0]        r_cnt;
  logic [PW-1:0]        r_ptr;
  logic [NUM_PORTS-1:0] r_rvalid;
  logic [NUM_PORTS-1:0] w_gnt;
  logic                 w_gnt_vld, w_gnt_any, w_locked;
  logic [PW-1:0]        w_gnt_idx;
`ifdef SRAM_ARB_LOCK_EN
  logic                 r_lock_hold;
  logic [PW-1:0]        r_lock_idx;
`endif

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] ptr, input int off);
    int v;
    v = int'(ptr) + 1 + off;
    if (v >= NUM_PORTS) v = v - NUM_PORTS;
    return v[PW-1:0];
  endfunction

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_locked  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_gnt_vld && bus.req_i[rr_idx(r_ptr, i)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = rr_idx(r_ptr, i);
      end
    end
`ifdef SRAM_ARB_LOCK_EN
    // A port that held its lock when last granted pre-empts round-robin order.
    if (r_lock_hold && bus.req_i[r_lock_idx]) begin
      w_gnt_vld = 1'b1;
      w_gnt_idx = r_lock_idx;
      w_locked  = 1'b1;
    end
`endif
  end

  assign w_gnt_any = (r_state == S_ARB) && w_gnt_vld;
  assign w_gnt     = w_gnt_any ? (NUM_PORTS'(1) << w_gnt_idx) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    case (r_state)
      S_INIT: begin
        sram_req_o  = 1'b1;
        sram_we_o   = 1'b1;
        sram_addr_o = r_cnt;
        sram_be_o   = '1;
        if (r_cnt == AW'(NUM_WORDS - 1)) w_state_nxt = S_ARB;
      end
      S_ARB: begin
        if (w_gnt_vld) begin
          sram_req_o   = 1'b1;
          sram_we_o    = bus.we_i[w_gnt_idx];
          sram_addr_o  = bus.addr_i[w_gnt_idx*AW +: AW];
          sram_wdata_o = bus.wdata_i[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
          sram_be_o    = bus.be_i[w_gnt_idx*BW +: BW];
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_ptr    <= PW'(NUM_PORTS - 1);
      r_rvalid <= '0;
    end else begin
      if (r_state == S_INIT) r_cnt <= r_cnt + AW'(1);
      r_rvalid <= (w_gnt_any && !bus.we_i[w_gnt_idx]) ? w_gnt : '0;
      // Locked re-grants leave the rotation where it was.
      if (w_gnt_any && !w_locked) r_ptr <= w_gnt_idx;
    end
  end

`ifdef SRAM_ARB_LOCK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lock_hold <= 1'b0;
      r_lock_idx  <= '0;
    end else begin
      r_lock_hold <= w_gnt_any && lock_i[w_gnt_idx];
      r_lock_idx  <= w_gnt_idx;
    end
  end
`endif

  assign bus.gnt_o       = w_gnt;
  assign bus.rvalid_o    = r_rvalid;
  assign bus.rdata_o     = sram_rdata_i;
  assign bus.init_done_o = (r_state == S_ARB);
endmodule
